// File: rtl/display_arbiter_pkg.sv
// Shared types and helpers for the display arbiter and its round-robin picker.
package display_arbiter_pkg;

    // Arbiter mode: free display (SHOW) or an event source pinned (HOLD).
    typedef enum logic {
        SHOW = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 upward, wrapping.
module rr_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int n_src = 4
) (
    input  logic [n_src-1:0]        req,
    input  logic [clog2(n_src)-1:0] last_grant,
    output logic [n_src-1:0]        grant,
    output logic [clog2(n_src)-1:0] grant_idx,
    output logic                    any
);

    localparam int iw = clog2(n_src);

    logic [iw-1:0] cand;

    // First requester after last_grant wins; last_grant itself is checked last.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int k = 1; k <= n_src; k++) begin
            // n_src is a power of two, so the index wraps by truncation.
            cand = last_grant + iw'(k);
            if (!any && req[cand]) begin
                any       = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = any;
    end

endmodule

// File: rtl/display_arbiter.sv
// Time-shares the seven-segment display between n_src value sources:
// auto-rotation or manual select by default, round-robin pinned events on req.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int n_src       = 4,
    parameter int w           = 32,
    parameter int dwell_width = 8,
    parameter int hold_ticks  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    auto,
    input  logic [clog2(n_src)-1:0] sel,
    input  logic [n_src-1:0]        req,
    input  logic [n_src*w-1:0]      data,
    output logic [n_src-1:0]        ack,
    output logic [w-1:0]            num,
    output logic [clog2(n_src)-1:0] src,
    output logic                    busy
);

    localparam int iw = clog2(n_src);
    // Wide enough to hold hold_ticks-1 even when hold_ticks is 1.
    localparam int hw = clog2(hold_ticks + 1);
    localparam logic [hw-1:0] hold_init = hw'(hold_ticks - 1);

    state_t                 state, state_nxt;
    logic [iw-1:0]          cur, cur_nxt;
    logic [iw-1:0]          last_grant, last_grant_nxt;
    logic [iw-1:0]          hold_src, hold_src_nxt;
    logic [dwell_width-1:0] dwell_cnt, dwell_nxt;
    logic [hw-1:0]          hold_cnt, hold_nxt;
    logic [n_src-1:0]       ack_nxt;
    logic [iw-1:0]          disp_idx;

    logic [n_src-1:0]       grant;
    logic [iw-1:0]          grant_idx;
    logic                   grant_any;

    logic [w-1:0]           slice [n_src];

    for (genvar i = 0; i < n_src; i++) begin : g_slice
        assign slice[i] = data[i*w +: w];
    end

    rr_arbiter #(
        .n_src (n_src)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    assign busy = (state == HOLD);

    // Next-state logic: rotation/manual tracking in SHOW, tick countdown in HOLD.
    always_comb begin
        state_nxt      = state;
        cur_nxt        = cur;
        last_grant_nxt = last_grant;
        hold_src_nxt   = hold_src;
        dwell_nxt      = dwell_cnt;
        hold_nxt       = hold_cnt;
        ack_nxt        = '0;
        disp_idx       = auto ? cur : sel;
        case (state)
            SHOW: begin
                if (!auto) begin
                    cur_nxt = sel;
                end
                // A pending request wins over a dwell tick in the same cycle.
                if (grant_any) begin
                    ack_nxt        = grant;
                    last_grant_nxt = grant_idx;
                    hold_src_nxt   = grant_idx;
                    hold_nxt       = hold_init;
                    state_nxt      = HOLD;
                end else if (auto && en) begin
                    dwell_nxt = dwell_cnt + dwell_width'(1);
                    if (&dwell_cnt) begin
                        cur_nxt = cur + iw'(1);
                    end
                end
            end
            HOLD: begin
                disp_idx = hold_src;
                if (en) begin
                    if (hold_cnt == '0) begin
                        state_nxt = SHOW;
                        dwell_nxt = '0;
                    end else begin
                        hold_nxt = hold_cnt - hw'(1);
                    end
                end
            end
            default: begin
                state_nxt = SHOW;
            end
        endcase
    end

    // State and output registers; num/src follow the displayed index one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SHOW;
            cur        <= '0;
            last_grant <= iw'(n_src - 1);
            hold_src   <= '0;
            dwell_cnt  <= '0;
            hold_cnt   <= '0;
            ack        <= '0;
            num        <= '0;
            src        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nxt;
            cur        <= cur_nxt;
            last_grant <= last_grant_nxt;
            hold_src   <= hold_src_nxt;
            dwell_cnt  <= dwell_nxt;
            hold_cnt   <= hold_nxt;
            ack        <= ack_nxt;
            num        <= slice[disp_idx];
            src        <= disp_idx;
        end
    end

endmodule
